contador_ad_param_2dig: RTL and testbench

- Parametrised two-digit up/down counter for the RTC time/date setting path (seconds, minutes, hours, days, months).
- Modulus and lower bound are configurable, so one block serves 0–59, 0–23, 1–31 and 1–12 fields.
- Adds hold-to-repeat stepping, synchronous load for RTC write-back, and carry/borrow ticks for cascading fields.
- Two BCD digits feed the display/formatting logic downstream.

---
 rtl/contador_ad_param_2dig.sv | 209 ++++++++++++++++++++
 tb/tb_contador_ad_param_2dig.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_ad_param_2dig.sv
// -----------------------------------------------------------------------------
// contador_ad_param_2dig
//
// Two-digit up/down counter used on the RTC time/date setting path. A single
// parameterisation covers every field: 0-59 (seconds/minutes), 0-23 (hours),
// 1-31 (days) and 1-12 (months).
//
// A button press steps the counter once. Holding the button for HOLD_CYC
// cycles after that first step starts auto-repeat, which then steps every
// REP_CYC cycles. A synchronous load lets the RTC write the current value
// back. Wrap-around produces one-cycle carry/borrow ticks so fields can be
// cascaded.
//
// Handshake/timing: enUP/enDOWN are levels. Only a rising level starts a press.
// A rise seen before clock edge k changes count at edge k. load is a strobe
// sampled on every edge and beats any button activity in that cycle.
//
// Ports:
//   clk          system clock, all state updates on posedge
//   reset        asynchronous, active-low reset (0 = in reset)
//   enUP         increment request level (debounced button)
//   enDOWN       decrement request level (debounced button)
//   load         synchronous load strobe
//   load_val     value to load; values outside [MIN, MAX] load MIN instead
//   count        registered binary count, always within [MIN, MAX]
//   digit1       BCD tens digit of count
//   digit0       BCD units digit of count
//   carry_tick   one-cycle pulse, coincident with an up step wrapping MAX->MIN
//   borrow_tick  one-cycle pulse, coincident with a down step wrapping MIN->MAX
//   fsm_state    debug view of the press FSM (0 = IDLE, 1 = HOLD, 2 = REPEAT)
// -----------------------------------------------------------------------------
module contador_ad_param_2dig #(
  parameter int N        = 6,
  parameter int MIN      = 0,
  parameter int MAX      = 59,
  parameter int HOLD_CYC = 1000,
  parameter int REP_CYC  = 250,
  parameter int TW       = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enUP,
  input  logic         enDOWN,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] count,
  output logic [3:0]   digit1,
  output logic [3:0]   digit0,
  output logic         carry_tick,
  output logic         borrow_tick,
  output logic [1:0]   fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam logic [N-1:0]  MIN_V     = N'(MIN);
  localparam logic [N-1:0]  MAX_V     = N'(MAX);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REP_CYC - 1);

  state_t        state, state_n;
  logic          dir, dir_n;          // 1 = up, 0 = down
  logic [TW-1:0] timer, timer_n;
  logic          enUP_reg, enDOWN_reg;
  logic          up_edge, down_edge;
  logic          en_dir;              // enable level for the direction being held
  logic          do_up, do_down;
  logic [N-1:0]  count_n;
  logic          carry_n, borrow_n;
  logic          load_in_range;
  logic [7:0]    cnt8;

  assign up_edge   = enUP & ~enUP_reg;
  assign down_edge = enDOWN & ~enDOWN_reg;
  assign en_dir    = dir ? enUP : enDOWN;
  assign fsm_state = state;

  // Compare in 32-bit signed space so MIN = 0 does not become an
  // always-true unsigned comparison.
  assign load_in_range = (int'(load_val) >= MIN) && (int'(load_val) <= MAX);

  // ---------------------------------------------------------------------------
  // Press FSM: decides when a step happens and in which direction.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    dir_n   = dir;
    timer_n = timer;
    do_up   = 1'b0;
    do_down = 1'b0;

    if (load) begin
      state_n = IDLE;
      timer_n = '0;
    end else if (enUP && enDOWN) begin
      // Both buttons (including the opposite one rising mid-hold) cancel the
      // press. Stepping resumes only after a fresh rising edge.
      state_n = IDLE;
      timer_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (up_edge) begin
            do_up   = 1'b1;
            dir_n   = 1'b1;
            timer_n = '0;
            state_n = HOLD;
          end else if (down_edge) begin
            do_down = 1'b1;
            dir_n   = 1'b0;
            timer_n = '0;
            state_n = HOLD;
          end
        end
        HOLD: begin
          if (!en_dir) begin
            state_n = IDLE;
            timer_n = '0;
          end else if (timer == HOLD_LAST) begin
            do_up   = dir;
            do_down = ~dir;
            timer_n = '0;
            state_n = REPEAT;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
        REPEAT: begin
          if (!en_dir) begin
            state_n = IDLE;
            timer_n = '0;
          end else if (timer == REP_LAST) begin
            do_up   = dir;
            do_down = ~dir;
            timer_n = '0;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          timer_n = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Count datapath with wrap and tick generation.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_n  = count;
    carry_n  = 1'b0;
    borrow_n = 1'b0;
    if (load) begin
      count_n = load_in_range ? load_val : MIN_V;
    end else if (do_up) begin
      if (count == MAX_V) begin
        count_n = MIN_V;
        carry_n = 1'b1;
      end else begin
        count_n = count + N'(1);
      end
    end else if (do_down) begin
      if (count == MIN_V) begin
        count_n  = MAX_V;
        borrow_n = 1'b1;
      end else begin
        count_n = count - N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      dir         <= 1'b1;
      timer       <= '0;
      count       <= MIN_V;
      carry_tick  <= 1'b0;
      borrow_tick <= 1'b0;
      // Start "already high" so a button held across reset release is not
      // mistaken for a new press.
      enUP_reg    <= 1'b1;
      enDOWN_reg  <= 1'b1;
    end else begin
      state       <= state_n;
      dir         <= dir_n;
      timer       <= timer_n;
      count       <= count_n;
      carry_tick  <= carry_n;
      borrow_tick <= borrow_n;
      enUP_reg    <= enUP;
      enDOWN_reg  <= enDOWN;
    end
  end

  // ---------------------------------------------------------------------------
  // BCD split by arithmetic rather than a lookup, so any MAX up to 99 works.
  // ---------------------------------------------------------------------------
  assign cnt8   = 8'(count);
  assign digit1 = 4'(cnt8 / 8'd10);
  assign digit0 = 4'(cnt8 % 8'd10);

endmodule

// File: tb/tb_contador_ad_param_2dig.sv
// -----------------------------------------------------------------------------
// tb_contador_ad_param_2dig
//
// Four counter instances cover the field configurations:
//   0: MIN=1, MAX=12   (months)  - reset with button held, load clamping
//   1: MIN=0, MAX=59   (seconds) - up wrap with carry
//   2: MIN=1, MAX=31   (days)    - down wrap with borrow
//   3: MIN=0, MAX=23, HOLD_CYC=4, REP_CYC=2 - auto-repeat and conflicts
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point after the next rising edge.
// -----------------------------------------------------------------------------
module tb_contador_ad_param_2dig;

  localparam int W      = 18;
  localparam int S_IDLE = 0;
  localparam int S_HOLD = 1;
  localparam int S_REP  = 2;

  logic       clk;
  logic       reset;
  logic       en_up     [4];
  logic       en_down   [4];
  logic       load_s    [4];
  logic [5:0] load_val_a[4];
  logic [5:0] count_a   [4];
  logic [3:0] digit1_a  [4];
  logic [3:0] digit0_a  [4];
  logic       carry_a   [4];
  logic       borrow_a  [4];
  logic [1:0] state_a   [4];

  logic [W-1:0] exp_q[$];
  int           inst_q[$];
  string        tag_q[$];

  int n_vec;
  int n_err;

  // Expected count/state while enUP is held on instance 3, one entry per
  // edge after the press edge.
  int rep_cnt[11] = '{1, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
  int rep_st [11] = '{1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2};

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUTs
  contador_ad_param_2dig #(.N(6), .MIN(1), .MAX(12)) u_mon (
    .clk(clk), .reset(reset), .enUP(en_up[0]), .enDOWN(en_down[0]),
    .load(load_s[0]), .load_val(load_val_a[0]), .count(count_a[0]),
    .digit1(digit1_a[0]), .digit0(digit0_a[0]), .carry_tick(carry_a[0]),
    .borrow_tick(borrow_a[0]), .fsm_state(state_a[0])
  );

  contador_ad_param_2dig #(.N(6), .MIN(0), .MAX(59)) u_sec (
    .clk(clk), .reset(reset), .enUP(en_up[1]), .enDOWN(en_down[1]),
    .load(load_s[1]), .load_val(load_val_a[1]), .count(count_a[1]),
    .digit1(digit1_a[1]), .digit0(digit0_a[1]), .carry_tick(carry_a[1]),
    .borrow_tick(borrow_a[1]), .fsm_state(state_a[1])
  );

  contador_ad_param_2dig #(.N(6), .MIN(1), .MAX(31)) u_day (
    .clk(clk), .reset(reset), .enUP(en_up[2]), .enDOWN(en_down[2]),
    .load(load_s[2]), .load_val(load_val_a[2]), .count(count_a[2]),
    .digit1(digit1_a[2]), .digit0(digit0_a[2]), .carry_tick(carry_a[2]),
    .borrow_tick(borrow_a[2]), .fsm_state(state_a[2])
  );

  contador_ad_param_2dig #(.N(6), .MIN(0), .MAX(23), .HOLD_CYC(4), .REP_CYC(2)) u_hr (
    .clk(clk), .reset(reset), .enUP(en_up[3]), .enDOWN(en_down[3]),
    .load(load_s[3]), .load_val(load_val_a[3]), .count(count_a[3]),
    .digit1(digit1_a[3]), .digit0(digit0_a[3]), .carry_tick(carry_a[3]),
    .borrow_tick(borrow_a[3]), .fsm_state(state_a[3])
  );

  // ---------------------------------------------------------------- scoreboard
  function automatic logic [W-1:0] obs(input int i);
    return {count_a[i], digit1_a[i], digit0_a[i], carry_a[i], borrow_a[i], state_a[i]};
  endfunction

  task automatic expect_out(input int i, input string tag, input int cnt,
                            input int d1, input int d0, input int c,
                            input int b, input int st);
    exp_q.push_back({6'(cnt), 4'(d1), 4'(d0), 1'(c), 1'(b), 2'(st)});
    inst_q.push_back(i);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    logic [W-1:0] e;
    logic [W-1:0] o;
    int           i;
    string        t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      i = inst_q.pop_front();
      t = tag_q.pop_front();
      o = obs(i);
      n_vec++;
      assert (o === e) else begin
        n_err++;
        $error("FAIL %s (u%0d): observed cnt=%0d d=%0d/%0d c=%0b b=%0b st=%0d, expected cnt=%0d d=%0d/%0d c=%0b b=%0b st=%0d",
               t, i, o[17:12], o[11:8], o[7:4], o[3], o[2], o[1:0],
               e[17:12], e[11:8], e[7:4], e[3], e[2], e[1:0]);
      end
    end
  endtask

  // ---------------------------------------------------------------- driver
  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 4; i++) begin
      en_up[i]      = 1'b0;
      en_down[i]    = 1'b0;
      load_s[i]     = 1'b0;
      load_val_a[i] = '0;
    end
    reset    = 1'b0;
    en_up[0] = 1'b1;   // button held through reset

    // Reset state, checked while reset is still asserted.
    repeat (2) @(posedge clk);
    #1;
    expect_out(0, "reset_mon", 1, 0, 1, 0, 0, S_IDLE);
    expect_out(3, "reset_hr",  0, 0, 0, 0, 0, S_IDLE);
    drain();

    // Release with enUP still high: no step.
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expect_out(0, "held_thru_reset", 1, 0, 1, 0, 0, S_IDLE);
      step();
    end
    en_up[0] = 1'b0;
    step();

    // Load clamp on 1..12.
    load_s[0] = 1'b1;
    load_val_a[0] = 6'd0;
    expect_out(0, "load_below_min", 1, 0, 1, 0, 0, S_IDLE);
    step();
    load_val_a[0] = 6'd13;
    expect_out(0, "load_above_max", 1, 0, 1, 0, 0, S_IDLE);
    step();
    load_val_a[0] = 6'd12;
    expect_out(0, "load_max", 12, 1, 2, 0, 0, S_IDLE);
    step();
    load_s[0] = 1'b0;
    expect_out(0, "load_hold", 12, 1, 2, 0, 0, S_IDLE);
    step();

    // Up wrap on 0..59.
    load_s[1] = 1'b1;
    load_val_a[1] = 6'd58;
    expect_out(1, "load_58", 58, 5, 8, 0, 0, S_IDLE);
    step();
    load_s[1] = 1'b0;
    en_up[1] = 1'b1;
    expect_out(1, "up_to_59", 59, 5, 9, 0, 0, S_HOLD);
    step();
    en_up[1] = 1'b0;
    expect_out(1, "release_59", 59, 5, 9, 0, 0, S_IDLE);
    step();
    en_up[1] = 1'b1;
    expect_out(1, "wrap_to_0", 0, 0, 0, 1, 0, S_HOLD);
    step();
    en_up[1] = 1'b0;
    expect_out(1, "carry_one_cycle", 0, 0, 0, 0, 0, S_IDLE);
    step();

    // Down wrap on 1..31.
    load_s[2] = 1'b1;
    load_val_a[2] = 6'd1;
    expect_out(2, "load_1", 1, 0, 1, 0, 0, S_IDLE);
    step();
    load_s[2] = 1'b0;
    en_down[2] = 1'b1;
    expect_out(2, "wrap_to_31", 31, 3, 1, 0, 1, S_HOLD);
    step();
    en_down[2] = 1'b0;
    expect_out(2, "borrow_one_cycle", 31, 3, 1, 0, 0, S_IDLE);
    step();

    // Auto-repeat on 0..23 with HOLD_CYC=4, REP_CYC=2: hold enUP 12 edges.
    en_up[3] = 1'b1;
    expect_out(3, "repeat_first", 1, 0, 1, 0, 0, S_HOLD);
    step();
    for (int k = 0; k < 11; k++) begin
      expect_out(3, $sformatf("repeat_edge%0d", k + 1), rep_cnt[k],
                 rep_cnt[k] / 10, rep_cnt[k] % 10, 0, 0, rep_st[k]);
      step();
    end
    en_up[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_out(3, "repeat_released", 5, 0, 5, 0, 0, S_IDLE);
      step();
    end

    // Both enables rising together.
    en_up[3] = 1'b1;
    en_down[3] = 1'b1;
    expect_out(3, "both_rise", 5, 0, 5, 0, 0, S_IDLE);
    step();
    en_up[3] = 1'b0;
    en_down[3] = 1'b0;
    expect_out(3, "both_release", 5, 0, 5, 0, 0, S_IDLE);
    step();

    // Into REPEAT, then raise enDOWN.
    en_up[3] = 1'b1;
    expect_out(3, "press_6", 6, 0, 6, 0, 0, S_HOLD);
    step();
    for (int k = 0; k < 3; k++) begin
      expect_out(3, "hold_6", 6, 0, 6, 0, 0, S_HOLD);
      step();
    end
    expect_out(3, "enter_repeat_7", 7, 0, 7, 0, 0, S_REP);
    step();
    en_down[3] = 1'b1;
    expect_out(3, "opposite_in_repeat", 7, 0, 7, 0, 0, S_IDLE);
    step();
    expect_out(3, "opposite_held", 7, 0, 7, 0, 0, S_IDLE);
    step();
    en_down[3] = 1'b0;
    expect_out(3, "up_level_no_edge", 7, 0, 7, 0, 0, S_IDLE);
    step();
    en_up[3] = 1'b0;
    expect_out(3, "all_released", 7, 0, 7, 0, 0, S_IDLE);
    step();

    // Load in the same cycle as an enUP edge.
    load_s[3] = 1'b1;
    load_val_a[3] = 6'd10;
    en_up[3] = 1'b1;
    expect_out(3, "load_beats_up", 10, 1, 0, 0, 0, S_IDLE);
    step();
    load_s[3] = 1'b0;
    expect_out(3, "held_after_load", 10, 1, 0, 0, 0, S_IDLE);
    step();
    expect_out(3, "held_after_load2", 10, 1, 0, 0, 0, S_IDLE);
    step();
    en_up[3] = 1'b0;
    expect_out(3, "release_after_load", 10, 1, 0, 0, 0, S_IDLE);
    step();
    en_down[3] = 1'b1;
    expect_out(3, "down_to_9", 9, 0, 9, 0, 0, S_HOLD);
    step();
    en_down[3] = 1'b0;
    expect_out(3, "down_release", 9, 0, 9, 0, 0, S_IDLE);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
